// File: rtl/fir_interp_pkg.sv
// functs: shared Q10 arithmetic helpers, the interpolator state enum and the default FM audio LPF taps.
package functs;
  localparam int QUANT_BITS = 10;
  typedef enum logic [1:0] {READ, RUN, WRITE} fir_interp_state_t;
  // Symmetric 32-tap low-pass in Q10; the taps sum to 4096 (unity DC gain times INTERPOLATION).
  localparam logic [31:0][31:0] FM_LPF_COEFF = {
    -32'sd3, -32'sd6, -32'sd12, -32'sd19, -32'sd27, -32'sd33, -32'sd30, -32'sd13,
    32'sd18, 32'sd70, 32'sd140, 32'sd225, 32'sd318, 32'sd405, 32'sd476, 32'sd539,
    32'sd539, 32'sd476, 32'sd405, 32'sd318, 32'sd225, 32'sd140, 32'sd70, 32'sd18,
    -32'sd13, -32'sd30, -32'sd33, -32'sd27, -32'sd19, -32'sd12, -32'sd6, -32'sd3};
  function automatic logic [31:0] mul_frac10_32b(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    p = p >>> QUANT_BITS;
    return p[31:0];
  endfunction
endpackage

// File: rtl/fir_interp_mac.sv
// fir_mac_q10: single Q10 multiply-accumulate with clear, wrapping in 32b two's complement.
module fir_mac_q10 import functs::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] coeff,
  input  logic [31:0] sample,
  output logic [31:0] acc
);
  logic [31:0] acc_q, acc_d;
  always_comb acc_d = clr ? '0 : en ? acc_q + mul_frac10_32b(coeff, sample) : acc_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/fir_interp.sv
// fir_interp: polyphase interpolating FIR, one pop then INTERPOLATION pushes, one MAC.
// Define FIR_INTERP_GAIN_EN to scale each output by INTERPOLATION.
module fir_interp import functs::*; #(
  parameter int TAP_NUMBER = 32,
  parameter int INTERPOLATION = 4,
  parameter logic [TAP_NUMBER-1:0][31:0] CONV_COEFF = FM_LPF_COEFF,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_wr_en,
  input  logic                  out_full
);
  localparam int PHASE_TAPS = TAP_NUMBER / INTERPOLATION;
  localparam int PW = INTERPOLATION > 1 ? $clog2(INTERPOLATION) : 1;
  localparam int TW = PHASE_TAPS > 1 ? $clog2(PHASE_TAPS) : 1;
  localparam int IW = TAP_NUMBER > 1 ? $clog2(TAP_NUMBER) : 1;
  if (INTERPOLATION < 1 || TAP_NUMBER % INTERPOLATION != 0) begin : g_bad_cfg
    $error("fir_interp: TAP_NUMBER must be a multiple of INTERPOLATION");
  end
  fir_interp_state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [DATA_WIDTH-1:0] hist_q [PHASE_TAPS];
  logic pop, push, run, last_tap, last_phase;
  logic [31:0] acc, coeff, sample, scaled;
  // Reset gates the handshakes so nothing is popped or pushed while it is held.
  assign pop = state_q == READ && !in_empty && !reset;
  assign push = state_q == WRITE && !out_full && !reset;
  assign run = state_q == RUN;
  assign last_tap = tap_q == TW'(PHASE_TAPS - 1);
  assign last_phase = phase_q == PW'(INTERPOLATION - 1);
  assign coeff = CONV_COEFF[IW'(int'(tap_q) * INTERPOLATION + int'(phase_q))];
  assign sample = 32'($signed(hist_q[tap_q]));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= READ;
      phase_q <= '0;
      tap_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tap_q <= tap_d;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < PHASE_TAPS; i++) hist_q[i] <= '0;
    else if (pop) begin
      hist_q[0] <= in_dout;
      for (int i = 1; i < PHASE_TAPS; i++) hist_q[i] <= hist_q[i-1];
    end
  always_comb begin
    state_d = pop ? RUN : (run && last_tap) ? WRITE : push ? (last_phase ? READ : RUN) : state_q;
    tap_d = (pop || push || (run && last_tap)) ? '0 : run ? tap_q + 1'b1 : tap_q;
    phase_d = (pop || (push && last_phase)) ? '0 : push ? phase_q + 1'b1 : phase_q;
  end
  always_comb begin
    in_rd_en = pop;
    out_wr_en = push;
    out_din = push ? DATA_WIDTH'(scaled) : '0;
  end
  fir_mac_q10 u_mac (
    .clock (clock),
    .reset (reset),
    .clr   (pop || push),
    .en    (run),
    .coeff (coeff),
    .sample(sample),
    .acc   (acc)
  );
`ifdef FIR_INTERP_GAIN_EN
  localparam bit POW2 = (INTERPOLATION & (INTERPOLATION - 1)) == 0;
  assign scaled = POW2 ? acc << $clog2(INTERPOLATION) : 32'(acc * 32'(INTERPOLATION));
`else
  assign scaled = acc;
`endif
endmodule

// File: tb/tb_fir_interp.sv
// tb_fir_interp: directed checks of the interpolating FIR against hand-computed Q10 results.
module tb_fir_interp;
`ifdef FIR_INTERP_GAIN_EN
  localparam int GAIN = 4;
`else
  localparam int GAIN = 1;
`endif
  localparam int IMP[8] = '{-3, -6, -12, -19, -27, -33, -30, -13};
  localparam int DC[4] = '{1038, 1010, 1010, 1038};
  logic clock = 0, reset = 1, in_empty = 1, out_full = 0, starve = 0, pend = 0;
  logic [31:0] in_dout = '0;
  logic in_rd_en, out_wr_en;
  logic [31:0] out_din;
  logic [31:0] in_q[$], outs[$];
  int pop_cyc[$], push_cyc[$];
  int total = 0, bad = 0, pops = 0, viol = 0, cyc = 0;
  always #5 clock = ~clock;
  fir_interp dut (
    .clock    (clock),
    .reset    (reset),
    .in_dout  (in_dout),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .out_din  (out_din),
    .out_wr_en(out_wr_en),
    .out_full (out_full)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask
  task automatic drive();
    in_empty = starve || in_q.size() == 0;
    in_dout = in_q.size() != 0 ? in_q[0] : '0;
  endtask
  task automatic tick();
    @(negedge clock);
    if (in_rd_en) begin pops++; pop_cyc.push_back(cyc); end
    if (out_wr_en) begin outs.push_back(out_din); push_cyc.push_back(cyc); end
    if (in_rd_en && out_wr_en) viol++;
    if (!out_wr_en && out_din !== '0) viol++;
    pend = in_rd_en;
    @(posedge clock);
    #1;
    if (pend && in_q.size() != 0) void'(in_q.pop_front());
    cyc++;
    drive();
  endtask
  task automatic clean();
    reset = 1;
    in_q.delete(); outs.delete(); pop_cyc.delete(); push_cyc.delete();
    pops = 0; viol = 0; starve = 0; out_full = 0;
    drive();
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
  endtask
  task automatic wait_outs(input int n);
    int b = 0;
    while (outs.size() < n && b < 500) begin tick(); b++; end
    chk("output_count", 32'(outs.size()), 32'(n));
  endtask
  task automatic wait_pop();
    int b = 0;
    while (pops < 1 && b < 100) begin tick(); b++; end
    chk("first_pop", 32'(pops), 32'd1);
  endtask
  task automatic chk_imp(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s[%0d]", tag, i), outs[i], 32'(GAIN * IMP[i]));
    chk({tag, "_handshake_viol"}, 32'(viol), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int sum;
    in_q = '{32'h400};
    drive();
    #12;
    chk("reset_rd_en", 32'(in_rd_en), 32'd0);
    chk("reset_wr_en", 32'(out_wr_en), 32'd0);
    chk("reset_out_din", out_din, 32'd0);
    // impulse
    clean();
    in_q = '{32'h400, 32'h0};
    drive();
    #1;
    chk("rd_en_in_read", 32'(in_rd_en), 32'd1);
    wait_outs(8);
    chk_imp("impulse");
    chk("first_push_latency", 32'(push_cyc[0] - pop_cyc[0]), 32'd9);
    chk("impulse_pops", 32'(pops), 32'd2);
    // dc
    clean();
    repeat (8) in_q.push_back(32'h400);
    drive();
    wait_outs(32);
    chk("dc_first", outs[0], 32'(GAIN * -3));
    sum = 0;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("dc_phase%0d", p), outs[28+p], 32'(GAIN * DC[p]));
      sum += $signed(outs[28+p]);
    end
    chk("dc_total", 32'(sum), 32'(GAIN * 4096));
    chk("input_period", 32'(pop_cyc[1] - pop_cyc[0]), 32'd37);
    chk("dc_handshake_viol", 32'(viol), 32'd0);
    // backpressure
    clean();
    in_q = '{32'h400, 32'h0};
    drive();
    wait_pop();
    out_full = 1;
    repeat (20) tick();
    chk("bp_no_push", 32'(outs.size()), 32'd0);
    chk("bp_no_pop", 32'(pops), 32'd1);
    chk("bp_wr_en", 32'(out_wr_en), 32'd0);
    out_full = 0;
    wait_outs(8);
    chk_imp("backpressure");
    // starvation
    clean();
    in_q = '{32'h400, 32'h0};
    drive();
    wait_pop();
    starve = 1;
    drive();
    repeat (50) tick();
    chk("starve_pops", 32'(pops), 32'd1);
    chk("starve_outs", 32'(outs.size()), 32'd4);
    chk("starve_rd_en", 32'(in_rd_en), 32'd0);
    starve = 0;
    drive();
    wait_outs(8);
    chk_imp("starvation");
    // reset during phase 2, tap 3
    clean();
    in_q = '{32'h400, 32'h0};
    drive();
    wait_pop();
    repeat (21) tick();
    chk("midrun_outs", 32'(outs.size()), 32'd2);
    reset = 1;
    #1;
    chk("midrun_rd_en", 32'(in_rd_en), 32'd0);
    chk("midrun_wr_en", 32'(out_wr_en), 32'd0);
    chk("midrun_out_din", out_din, 32'd0);
    @(posedge clock);
    #1;
    in_q = '{32'h400, 32'h0};
    outs.delete(); pop_cyc.delete(); push_cyc.delete();
    pops = 0; viol = 0;
    drive();
    reset = 0;
    wait_outs(8);
    chk_imp("after_reset");
    chk("after_reset_latency", 32'(push_cyc[0] - pop_cyc[0]), 32'd9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
